// File: rtl/spi_pixel_buffer.sv
// spi_pixel_buffer
//   Receives RGB frames over a mode-0 SPI link into a double-buffered frame
//   store and hands complete frames to a downstream LED serializer.
//   A frame is 3*NUM_LEDS bytes (R,G,B per LED, LED 0 first) sent inside a
//   single CS-low window. Only a frame of exactly that length is queued for
//   display. The bank swap waits until the serializer is idle and CS is high.
//
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   spi_sck/mosi/cs_n SPI slave inputs (asynchronous to clk)
//   address           LED index requested by the serializer
//   data_request      capture display_bank[address] into the colour outputs
//   reset_state       serializer is idle in its reset/latch-wait state
//   start             one-cycle pulse to start transmission of the display bank
//   red/green/blue_out registered colour of the requested LED
//   frame_error       one-cycle pulse when a frame had the wrong length
//   busy              display FSM is not idle
module spi_pixel_buffer #(
  parameter int NUM_LEDS = 8,
  parameter int AW       = $clog2(NUM_LEDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          spi_sck,
  input  logic          spi_mosi,
  input  logic          spi_cs_n,
  input  logic [AW-1:0] address,
  input  logic          data_request,
  input  logic          reset_state,
  output logic          start,
  output logic [7:0]    red_out,
  output logic [7:0]    green_out,
  output logic [7:0]    blue_out,
  output logic          frame_error,
  output logic          busy
);

  localparam int FRAME_BYTES = 3 * NUM_LEDS;
  localparam int BW          = $clog2(FRAME_BYTES + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SWAP      = 3'd1;
  localparam logic [2:0] S_START     = 3'd2;
  localparam logic [2:0] S_WAIT_BUSY = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;

  logic [1:0]    r_sck_sync, r_mosi_sync, r_cs_sync;
  logic          r_sck_prev, r_cs_prev;
  logic [7:0]    r_shift;
  logic [2:0]    r_bit_cnt;
  logic [BW-1:0] r_byte_cnt;
  logic [AW-1:0] r_led;
  logic [1:0]    r_color;
  logic          r_too_long;
  logic          r_wr_en;
  logic [AW:0]   r_wr_addr;
  logic [1:0]    r_wr_color;
  logic [2:0]    r_state;
  logic          r_bank_sel;
  logic          r_swap_pending;
  logic          r_frame_error;

  logic [7:0]    r_red_mem   [0:2*NUM_LEDS-1];
  logic [7:0]    r_green_mem [0:2*NUM_LEDS-1];
  logic [7:0]    r_blue_mem  [0:2*NUM_LEDS-1];

  logic          w_sck, w_mosi, w_cs_n;
  logic          w_sck_rise, w_cs_fall, w_cs_rise;
  logic          w_shift_en, w_byte_done, w_in_range, w_frame_ok;
  logic [AW:0]   w_rd_addr;

  // Two-flop synchronizers plus one history flop for edge detection; idle
  // levels are CS high, SCK low, MOSI low so reset never fakes an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sck_sync  <= 2'b00;
      r_mosi_sync <= 2'b00;
      r_cs_sync   <= 2'b11;
      r_sck_prev  <= 1'b0;
      r_cs_prev   <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[0], spi_sck};
      r_mosi_sync <= {r_mosi_sync[0], spi_mosi};
      r_cs_sync   <= {r_cs_sync[0], spi_cs_n};
      r_sck_prev  <= r_sck_sync[1];
      r_cs_prev   <= r_cs_sync[1];
    end
  end

  assign w_sck       = r_sck_sync[1];
  assign w_mosi      = r_mosi_sync[1];
  assign w_cs_n      = r_cs_sync[1];
  assign w_sck_rise  = w_sck & ~r_sck_prev;
  assign w_cs_fall   = ~w_cs_n & r_cs_prev;
  assign w_cs_rise   = w_cs_n & ~r_cs_prev;
  assign w_shift_en  = w_sck_rise & ~w_cs_n & ~w_cs_fall;
  assign w_byte_done = w_shift_en & (r_bit_cnt == 3'd7);
  // The byte counter saturates at the frame length; anything beyond that is
  // remembered only through r_too_long.
  assign w_in_range  = (r_byte_cnt != BW'(FRAME_BYTES));
  assign w_frame_ok  = (r_byte_cnt == BW'(FRAME_BYTES)) & ~r_too_long;

  // SPI receiver: LED index and colour slot are tracked as counters that
  // advance alongside the byte count, which avoids a divide-by-3.
  // A completed byte is written one cycle later, once it sits whole in r_shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_led      <= '0;
      r_color    <= '0;
      r_too_long <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_color <= '0;
    end else begin
      r_wr_en <= w_byte_done & w_in_range;
      if (w_cs_fall) begin
        r_shift    <= '0;
        r_bit_cnt  <= '0;
        r_byte_cnt <= '0;
        r_led      <= '0;
        r_color    <= '0;
        r_too_long <= 1'b0;
      end else if (w_shift_en) begin
        r_shift   <= {r_shift[6:0], w_mosi};
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          if (w_in_range) begin
            r_wr_addr  <= {~r_bank_sel, r_led};
            r_wr_color <= r_color;
            r_byte_cnt <= r_byte_cnt + BW'(1);
            if (r_color == 2'd2) begin
              r_color <= 2'd0;
              r_led   <= r_led + AW'(1);
            end else begin
              r_color <= r_color + 2'd1;
            end
          end else begin
            r_too_long <= 1'b1;
          end
        end
      end
    end
  end

  // Frame store; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (r_wr_en) begin
      case (r_wr_color)
        2'd0:    r_red_mem[r_wr_addr]   <= r_shift;
        2'd1:    r_green_mem[r_wr_addr] <= r_shift;
        default: r_blue_mem[r_wr_addr]  <= r_shift;
      endcase
    end
  end

  // Display FSM, swap request and frame error. When a new valid frame ends
  // in the same cycle SWAP clears the request, the new request survives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_bank_sel     <= 1'b0;
      r_swap_pending <= 1'b0;
      r_frame_error  <= 1'b0;
    end else begin
      r_frame_error <= w_cs_rise & ~w_frame_ok;
      if (w_cs_rise && w_frame_ok) begin
        r_swap_pending <= 1'b1;
      end else if (r_state == S_SWAP) begin
        r_swap_pending <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (r_swap_pending && reset_state && w_cs_n) r_state <= S_SWAP;
        end
        S_SWAP: begin
          r_bank_sel <= ~r_bank_sel;
          r_state    <= S_START;
        end
        S_START:     r_state <= S_WAIT_BUSY;
        S_WAIT_BUSY: if (!reset_state) r_state <= S_WAIT_DONE;
        S_WAIT_DONE: if (reset_state) r_state <= S_IDLE;
        default:     r_state <= S_IDLE;
      endcase
    end
  end

  assign w_rd_addr = {r_bank_sel, address};

  // Colour outputs read only the display bank and hold between requests.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      red_out   <= '0;
      green_out <= '0;
      blue_out  <= '0;
    end else if (data_request) begin
      red_out   <= r_red_mem[w_rd_addr];
      green_out <= r_green_mem[w_rd_addr];
      blue_out  <= r_blue_mem[w_rd_addr];
    end
  end

  assign start       = (r_state == S_START);
  assign busy        = (r_state != S_IDLE);
  assign frame_error = r_frame_error;

endmodule

// File: tb/tb_spi_pixel_buffer.sv
// tb_spi_pixel_buffer
//   Drives SPI frames into spi_pixel_buffer and compares start/frame_error
//   pulse counts, busy and colour readback against a reference model.
//   The model holds both banks as byte arrays, a display-bank index, a
//   pending-frame flag and the serializer handshake phase.
module tb_spi_pixel_buffer;

  localparam int NUM_LEDS    = 8;
  localparam int AW          = $clog2(NUM_LEDS);
  localparam int FRAME_BYTES = 3 * NUM_LEDS;
  localparam int HALF_SCK    = 50;

  logic          clk          = 1'b0;
  logic          reset        = 1'b1;
  logic          spi_sck      = 1'b0;
  logic          spi_mosi     = 1'b0;
  logic          spi_cs_n     = 1'b1;
  logic [AW-1:0] address      = '0;
  logic          data_request = 1'b0;
  logic          reset_state  = 1'b1;
  logic          start;
  logic [7:0]    red_out, green_out, blue_out;
  logic          frame_error;
  logic          busy;

  int checkCount  = 0;
  int errorCount  = 0;
  int startPulses = 0;
  int errorPulses = 0;
  int expStarts   = 0;
  int expErrors   = 0;

  // modelPhase: 0 serializer idle, 1 started but not yet transmitting,
  // 2 transmitting (reset_state low after a start)
  logic [7:0] modelBank [0:1][0:NUM_LEDS-1][0:2];
  int         modelSel     = 0;
  int         modelPending = 0;
  int         modelPhase   = 0;
  logic [7:0] frameBytes [0:FRAME_BYTES+3];

  spi_pixel_buffer #(.NUM_LEDS(NUM_LEDS)) dut (
    .clk          (clk),
    .reset        (reset),
    .spi_sck      (spi_sck),
    .spi_mosi     (spi_mosi),
    .spi_cs_n     (spi_cs_n),
    .address      (address),
    .data_request (data_request),
    .reset_state  (reset_state),
    .start        (start),
    .red_out      (red_out),
    .green_out    (green_out),
    .blue_out     (blue_out),
    .frame_error  (frame_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled on the falling edge, away from register updates.
  always @(negedge clk) begin
    if (start === 1'b1) startPulses++;
    if (frame_error === 1'b1) errorPulses++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic modelTrySwap();
    if (modelPhase == 0 && modelPending != 0 && reset_state == 1'b1) begin
      modelSel     = 1 - modelSel;
      modelPending = 0;
      modelPhase   = 1;
      expStarts++;
    end
  endtask

  task automatic setResetState(input logic v);
    @(negedge clk);
    reset_state = v;
    waitCycles(10);
    if (!v && modelPhase == 1) modelPhase = 2;
    if (v && modelPhase == 2) modelPhase = 0;
    modelTrySwap();
  endtask

  task automatic spiByte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = b[i];
      #(HALF_SCK);
      spi_sck = 1'b1;
      #(HALF_SCK);
      spi_sck = 1'b0;
    end
  endtask

  task automatic sendBytes(input int nBytes);
    for (int n = 0; n < nBytes; n++) begin
      spiByte(frameBytes[n]);
      if (n < FRAME_BYTES) modelBank[1 - modelSel][n / 3][n % 3] = frameBytes[n];
    end
  endtask

  task automatic applyStimulus(input int nBytes);
    @(negedge clk);
    spi_cs_n = 1'b0;
    #100;
    sendBytes(nBytes);
    #100;
    spi_cs_n = 1'b1;
    waitCycles(12);
    if (nBytes == FRAME_BYTES) modelPending = 1;
    else expErrors++;
    modelTrySwap();
  endtask

  task automatic fillRandom(input int nBytes);
    for (int i = 0; i < nBytes; i++) frameBytes[i] = 8'($urandom);
  endtask

  task automatic checkState(input string tag);
    checkOutput($sformatf("%s_starts", tag), startPulses, expStarts);
    checkOutput($sformatf("%s_errors", tag), errorPulses, expErrors);
    checkOutput($sformatf("%s_busy", tag), busy, (modelPhase != 0));
  endtask

  task automatic readLed(input int idx);
    @(negedge clk);
    address      = AW'(idx);
    data_request = 1'b1;
    @(negedge clk);
    data_request = 1'b0;
  endtask

  task automatic checkAllLeds(input string tag);
    for (int i = 0; i < NUM_LEDS; i++) begin
      readLed(i);
      checkOutput($sformatf("%s_led%0d_r", tag, i), red_out,   modelBank[modelSel][i][0]);
      checkOutput($sformatf("%s_led%0d_g", tag, i), green_out, modelBank[modelSel][i][1]);
      checkOutput($sformatf("%s_led%0d_b", tag, i), blue_out,  modelBank[modelSel][i][2]);
    end
  endtask

  task automatic drainSerializer();
    for (int g = 0; g < 3 && modelPhase != 0; g++) begin
      setResetState(1'b0);
      setResetState(1'b1);
    end
  endtask

  initial begin
    int   kind;
    int   len;
    logic holdOff;

    waitCycles(3);
    reset = 1'b0;
    waitCycles(2);
    checkOutput("rst_start", start, 1'b0);
    checkOutput("rst_ferr", frame_error, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_red", red_out, 8'h00);
    checkOutput("rst_green", green_out, 8'h00);
    checkOutput("rst_blue", blue_out, 8'h00);

    // Valid frame with a known pattern, serializer idle.
    for (int i = 0; i < NUM_LEDS; i++) begin
      frameBytes[3*i]   = 8'(i);
      frameBytes[3*i+1] = 8'(8'h10 + i);
      frameBytes[3*i+2] = 8'(8'h20 + i);
    end
    applyStimulus(FRAME_BYTES);
    checkState("valid");
    readLed(3);
    checkOutput("valid_addr3_r", red_out, 8'h03);
    checkOutput("valid_addr3_g", green_out, 8'h13);
    checkOutput("valid_addr3_b", blue_out, 8'h23);
    checkAllLeds("valid");
    @(negedge clk);
    address = AW'(5);
    waitCycles(4);
    checkOutput("hold_r", red_out, 8'h07);
    checkOutput("hold_b", blue_out, 8'h27);
    setResetState(1'b0);
    setResetState(1'b1);
    checkState("valid_done");

    // Short frame: error pulse, no swap.
    fillRandom(FRAME_BYTES - 1);
    applyStimulus(FRAME_BYTES - 1);
    checkState("short");
    checkAllLeds("short");

    // Long frame: error pulse, no swap, display untouched.
    fillRandom(FRAME_BYTES + 1);
    applyStimulus(FRAME_BYTES + 1);
    checkState("long");
    checkAllLeds("long");

    // Frame completing while the serializer transmits.
    fillRandom(FRAME_BYTES);
    applyStimulus(FRAME_BYTES);
    checkState("tx_frame1");
    setResetState(1'b0);
    fillRandom(FRAME_BYTES);
    applyStimulus(FRAME_BYTES);
    checkState("tx_frame2_held");
    checkAllLeds("tx_reads_frame1");
    setResetState(1'b1);
    checkState("tx_frame2_start");
    checkAllLeds("tx_frame2");
    drainSerializer();
    checkState("tx_done");

    // Two frames while the serializer holds reset_state low.
    setResetState(1'b0);
    fillRandom(FRAME_BYTES);
    applyStimulus(FRAME_BYTES);
    fillRandom(FRAME_BYTES);
    applyStimulus(FRAME_BYTES);
    checkState("b2b_held");
    setResetState(1'b1);
    checkState("b2b_start");
    checkAllLeds("b2b");
    drainSerializer();

    // Reset in the middle of a frame.
    fillRandom(FRAME_BYTES);
    @(negedge clk);
    spi_cs_n = 1'b0;
    #100;
    sendBytes(10);
    #100;
    reset = 1'b1;
    waitCycles(2);
    checkOutput("rstmid_busy", busy, 1'b0);
    checkOutput("rstmid_red", red_out, 8'h00);
    checkOutput("rstmid_blue", blue_out, 8'h00);
    spi_cs_n = 1'b1;
    waitCycles(3);
    reset = 1'b0;
    modelSel     = 0;
    modelPending = 0;
    modelPhase   = 0;
    waitCycles(10);
    checkState("rstmid_idle");
    fillRandom(FRAME_BYTES);
    applyStimulus(FRAME_BYTES);
    checkState("rstmid_frame");
    checkAllLeds("rstmid_frame");
    drainSerializer();

    // Randomized frame lengths and serializer timing.
    for (int it = 0; it < 5; it++) begin
      kind = int'($urandom_range(0, 3));
      case (kind)
        0:       len = FRAME_BYTES;
        1:       len = FRAME_BYTES - 1;
        2:       len = FRAME_BYTES + 1;
        default: len = int'($urandom_range(1, FRAME_BYTES + 2));
      endcase
      holdOff = 1'($urandom_range(0, 1));
      fillRandom(len);
      if (holdOff) setResetState(1'b0);
      applyStimulus(len);
      checkState($sformatf("rand%0d_sent", it));
      if (holdOff) setResetState(1'b1);
      checkState($sformatf("rand%0d_rel", it));
      checkAllLeds($sformatf("rand%0d", it));
      drainSerializer();
      checkState($sformatf("rand%0d_idle", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  initial begin
    #3_000_000;
    errorCount++;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/spi_pixel_buffer.md
SPI_PIXEL_BUFFER -- requirements
Module: spi_pixel_buffer

Interface
REQ-001 Parameter NUM_LEDS, default 8: number of LEDs in the chain; SHALL be a power of two, at least 2.
REQ-002 Parameter AW, default $clog2(NUM_LEDS): LED address width.
REQ-003 clk  input  1: single system clock; all logic SHALL be in this domain.
REQ-004 reset  input  1: asynchronous, active-high reset.
REQ-005 spi_sck  input  1: SPI clock from host (mode 0), asynchronous to clk.
REQ-006 spi_mosi  input  1: SPI data from host, asynchronous to clk.
REQ-007 spi_cs_n  input  1: SPI chip select, active low, asynchronous to clk.
REQ-008 address  input  AW: LED index requested by the downstream serializer.
REQ-009 data_request  input  1: serializer will sample the colour outputs on the next cycle.
REQ-010 reset_state  input  1: serializer is idle in its reset/latch-wait state.
REQ-011 start  output  1: one-cycle pulse that starts serializer transmission of the display bank.
REQ-012 red_out, green_out, blue_out  output  8 each: colour of LED `address` from the display bank.
REQ-013 frame_error  output  1: one-cycle pulse when a received frame has the wrong length.
REQ-014 busy  output  1: high whenever the display FSM is not in IDLE.

Function
REQ-015 spi_sck, spi_mosi and spi_cs_n SHALL each pass through a 2-flop synchronizer; edges SHALL be detected on the synchronized signals; clk SHALL be at least 8x the SCK frequency.
REQ-016 On a synchronized SCK rising edge with CS low, the block SHALL shift MOSI into a byte shift register, MSB first.
REQ-017 A 3-bit bit counter SHALL wrap on the 8th bit and emit one received byte.
REQ-018 A byte counter SHALL count received bytes in the current CS-low window.
REQ-019 Each LED SHALL occupy 3 bytes in the order R, G, B; LED 0 SHALL come first.
REQ-020 Byte n SHALL be written to the back bank at LED n/3, colour n mod 3.
REQ-021 Bytes with n >= 3*NUM_LEDS SHALL be discarded and SHALL mark the frame as too long.
REQ-022 On a synchronized CS falling edge, the bit and byte counters SHALL clear, discarding any partial byte.
REQ-023 On a synchronized CS rising edge with a byte count of exactly 3*NUM_LEDS, the block SHALL set swap_pending.
REQ-024 On a CS rising edge with any other byte count, the block SHALL pulse frame_error for one cycle and leave swap_pending unchanged.
REQ-025 The frame buffer SHALL consist of two banks of NUM_LEDS x 24 bits; a bank-select bit SHALL choose the display bank, and the back bank SHALL be the other one.
REQ-026 While swap_pending is set, a newly completed frame SHALL overwrite the back bank: the last complete frame wins.
REQ-027 The display FSM SHALL have the states IDLE, SWAP, START, WAIT_BUSY and WAIT_DONE.
REQ-028 IDLE -> SWAP when swap_pending=1, reset_state=1 and synchronized CS high; otherwise the FSM SHALL stay in IDLE.
REQ-029 SWAP: the FSM SHALL toggle the bank-select bit, clear swap_pending, then go to START.
REQ-030 START: the FSM SHALL drive start=1 for this cycle only, then go to WAIT_BUSY.
REQ-031 WAIT_BUSY: the FSM SHALL stay until reset_state=0, then go to WAIT_DONE.
REQ-032 WAIT_DONE: the FSM SHALL stay until reset_state=1, then go to IDLE.
REQ-033 No bank swap SHALL occur while the serializer is transmitting or while CS is low.
REQ-034 If a CS rising edge that sets swap_pending coincides with SWAP clearing it, the set SHALL win.
REQ-035 In the cycle data_request=1, the colour outputs SHALL register display_bank[address]; the colour outputs SHALL otherwise hold.
REQ-036 The registered colour value SHALL be valid on the cycle after data_request.
REQ-037 Back-bank writes SHALL never alter the colour outputs.

Reset
REQ-038 Asserting reset at any time SHALL immediately return the block to the following state: FSM IDLE, start=0, frame_error=0, busy=0, colour outputs 0, bank select 0, swap_pending 0, counters 0, shift register 0, synchronizers at the idle levels (CS high, SCK low, MOSI low).
REQ-039 Buffer contents SHALL NOT be required to clear on reset; a reset mid-frame SHALL discard that frame.

Verification
REQ-040 Scenario, valid frame: NUM_LEDS=8, send 24 bytes LED i = (i, 0x10+i, 0x20+i), reset_state=1 -> one start pulse; a data_request with address=3 -> outputs 0x03/0x13/0x23 on the next cycle.
REQ-041 Scenario, short frame: send 23 bytes, then raise CS -> frame_error pulses once, no start pulse, the display bank is unchanged.
REQ-042 Scenario, long frame: send 25 bytes -> frame_error pulses once, the 25th byte is not written, no start pulse.
REQ-043 Scenario, frame during transmission: frame 2 completes while reset_state=0 -> no swap or start until reset_state returns to 1, then exactly one start; reads during transmission return frame 1.
REQ-044 Scenario, back-to-back frames: two frames complete while reset_state=0 -> after reset_state=1, exactly one start and the display shows the second frame.
REQ-045 Scenario, reset mid-frame: assert reset after 10 bytes, release it, send a full frame -> exactly one start, bank select = 1, correct data on readback.
